isa_vram_arbiter: RTL

Time-slot arbiter between the ISA memory-cycle decoder and the single 8-bit asynchronous video SRAM. It interleaves fixed video-fetch slots (character + attribute byte pairs for the CRTC/pixel pipeline) with one CPU slot per round, and holds the ISA bus in wait state via `bus_rdy_l` until the CPU byte has been read or written. It sits directly downstream of the ISA address decode in the MDA/CGA top levels and directly upstream of the SRAM pins.

---
 rtl/isa_vram_arbiter.sv | 89 ++++++++
 1 files changed

// File: rtl/isa_vram_arbiter.sv
// isa_vram_arbiter: slot arbiter sharing one async video SRAM between video fetch and ISA CPU cycles
module isa_vram_arbiter #(
    parameter int ADDR_WIDTH = 19
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  isa_sel,
    input  logic [ADDR_WIDTH-1:0] isa_a,
    input  logic                  bus_memr_l,
    input  logic                  bus_memw_l,
    input  logic [7:0]            isa_din,
    output logic [7:0]            isa_dout,
    output logic                  bus_rdy_l,
    input  logic [ADDR_WIDTH-2:0] vid_addr,
    output logic [7:0]            vid_char,
    output logic [7:0]            vid_attr,
    output logic                  vid_valid,
    output logic [ADDR_WIDTH-1:0] ram_a,
    output logic [7:0]            ram_d_out,
    output logic                  ram_d_oe,
    input  logic [7:0]            ram_d_in,
    output logic                  ram_ce_l,
    output logic                  ram_oe_l,
    output logic                  ram_we_l
);
    typedef enum logic [1:0] {IDLE, PEND, ACC, DONE} state_t;
    state_t state, state_nx;
    logic [1:0] slot;
    logic [1:0] rd_sync, wr_sync, sel_sync, prime;
    logic armed, cpu_rd, start, acc, strobes_high;
    logic [ADDR_WIDTH-1:0] cpu_a;
    assign strobes_high = rd_sync[1] & wr_sync[1];
    assign start = (state == IDLE) & armed & sel_sync[1] & (rd_sync[1] ^ wr_sync[1]);
    assign acc = (state == ACC);
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: state_nx = start ? PEND : IDLE;
            PEND: state_nx = (slot == 2'd1) ? ACC : PEND;
            ACC: state_nx = DONE;
            DONE: state_nx = strobes_high ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end
    // armed stays low until strobes are seen high after reset, so a strobe held across reset is ignored
    always_ff @(posedge clk) begin
        if (reset) begin
            slot <= 2'd0;
            rd_sync <= 2'b11;
            wr_sync <= 2'b11;
            sel_sync <= 2'b11;
            prime <= 2'b00;
            armed <= 1'b0;
            cpu_a <= '0;
            cpu_rd <= 1'b0;
            ram_d_out <= 8'h00;
            isa_dout <= 8'h00;
            vid_char <= 8'h00;
            vid_attr <= 8'h00;
            vid_valid <= 1'b0;
        end else begin
            slot <= slot + 2'd1;
            rd_sync <= {rd_sync[0], bus_memr_l};
            wr_sync <= {wr_sync[0], bus_memw_l};
            sel_sync <= {sel_sync[0], isa_sel};
            prime <= {prime[0], 1'b1};
            armed <= armed | (prime[1] & strobes_high);
            if (start) begin
                cpu_a <= isa_a;
                cpu_rd <= ~rd_sync[1];
                ram_d_out <= isa_din;
            end
            if (acc && cpu_rd) isa_dout <= ram_d_in;
            if (slot == 2'd0) vid_char <= ram_d_in;
            if (slot == 2'd1) vid_attr <= ram_d_in;
            vid_valid <= (slot == 2'd1);
        end
    end
    assign bus_rdy_l = (state == PEND) | acc;
    assign ram_ce_l = reset;
    assign ram_oe_l = reset | ~(~slot[1] | (acc & cpu_rd));
    assign ram_we_l = reset | ~(acc & ~cpu_rd);
    assign ram_d_oe = ~reset & acc & ~cpu_rd;
    assign ram_a = reset ? '0 : (slot[1] ? cpu_a : {vid_addr, slot[0]});
endmodule
